// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the loadable instruction memory and the 16-bit MIPS
// datapath: instruction width default, the word returned on an out-of-range
// fetch, and the RUN/LOAD state encoding of the memory controller.
// -----------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int IMEM_DATA_W = 16;

  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_t;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable_if
// Bundles the fetch port and the streaming program-load port of the
// instruction memory.
//   slave  : memory side (inputs are requests/load stream, outputs are
//            Fetch_Ready, Data_Out, Data_Valid, Fetch_Fault, Load_Busy,
//            Load_Ovf)
//   master : fetch stage / host side, the mirror image
// -----------------------------------------------------------------------------
interface instr_mem_loadable_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Fetch side
  logic              Fetch_Req;
  logic [ADDR_W-1:0] Addr;
  logic              Fetch_Ready;
  logic [DATA_W-1:0] Data_Out;
  logic              Data_Valid;
  logic              Fetch_Fault;

  // Program-load side
  logic              Load_Start;
  logic [ADDR_W-1:0] Load_Base;
  logic              Load_Valid;
  logic [DATA_W-1:0] Load_Data;
  logic              Load_Last;
  logic              Load_Busy;
  logic              Load_Ovf;

  modport slave (
    input  Fetch_Req, Addr, Load_Start, Load_Base, Load_Valid, Load_Data,
           Load_Last,
    output Fetch_Ready, Data_Out, Data_Valid, Fetch_Fault, Load_Busy, Load_Ovf
  );

  modport master (
    output Fetch_Req, Addr, Load_Start, Load_Base, Load_Valid, Load_Data,
           Load_Last,
    input  Fetch_Ready, Data_Out, Data_Valid, Fetch_Fault, Load_Busy, Load_Ovf
  );

endinterface

// File: rtl/instr_mem_loadable_imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Single-port synchronous RAM, DEPTH x DATA_W, with write enable and a
// registered read. Contents are never reset.
//   clk     : rising-edge clock
//   we_i    : write wdata_i to addr_i at this edge
//   re_i    : capture mem[addr_i] into the read register at this edge
//   addr_i  : shared word address
//   wdata_i : write data
//   rdata_o : registered read data (holds when re_i=0)
// -----------------------------------------------------------------------------
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
// Synchronous instruction memory for the 16-bit MIPS datapath with a run-time
// program-load port. A two-state controller (RUN / LOAD) arbitrates between
// instruction fetch and program writes; fetch and load never overlap, so the
// single-port RAM never sees a read/write collision.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high; clears control state, not the RAM
//   bus   : instr_mem_loadable_if.slave
//           Fetch_Req/Addr -> Data_Out/Data_Valid/Fetch_Fault one edge later
//           Fetch_Ready    : combinational, 1 in RUN unless Load_Start=1
//           Load_Start/Load_Base/Load_Valid/Load_Data/Load_Last : load stream
//           Load_Busy      : registered, 1 while in LOAD
//           Load_Ovf       : sticky, write attempted past the end of memory
// -----------------------------------------------------------------------------
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  instr_mem_loadable_if.slave  bus
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range limit held one bit wider than the address so DEPTH=2**ADDR_W fits.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  imem_state_t       state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              valid_q;
  logic              fault_q;
  // Selects NOP_WORD on Data_Out; updated only by accepted fetches so an
  // out-of-range result is held just like a real RAM word.
  logic              nop_sel_q;

  logic              fetch_acc;
  logic              fetch_in_range;
  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign bus.Fetch_Ready = (state_q == ST_RUN) && !bus.Load_Start;
  assign fetch_acc       = bus.Fetch_Req && bus.Fetch_Ready;
  assign fetch_in_range  = {1'b0, bus.Addr} < DEPTH_L;
  assign ram_re          = fetch_acc && fetch_in_range;
  assign ram_addr        = (state_q == ST_LOAD) ? ptr_q[AW-1:0] : bus.Addr[AW-1:0];

  // Next-state logic: Load_Start always wins and restarts the load, so a
  // same-cycle Load_Valid is dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    ram_we  = 1'b0;
    if (bus.Load_Start) begin
      state_d = ST_LOAD;
      ptr_d   = {1'b0, bus.Load_Base};
      ovf_d   = 1'b0;
    end else if ((state_q == ST_LOAD) && bus.Load_Valid) begin
      if (ptr_q < DEPTH_L) begin
        ram_we = !Reset;
        ptr_d  = ptr_q + PTR_ONE;
        if (bus.Load_Last) begin
          state_d = ST_RUN;
        end
      end else begin
        ovf_d   = 1'b1;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      nop_sel_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      valid_q <= fetch_acc;
      fault_q <= fetch_acc && !fetch_in_range;
      if (fetch_acc) begin
        nop_sel_q <= !fetch_in_range;
      end
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (Clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (bus.Load_Data),
    .rdata_o (ram_rdata)
  );

  assign bus.Data_Out    = nop_sel_q ? NOP_WORD : ram_rdata;
  assign bus.Data_Valid  = valid_q;
  assign bus.Fetch_Fault = fault_q;
  assign bus.Load_Busy   = (state_q == ST_LOAD);
  assign bus.Load_Ovf    = ovf_q;

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Synchronous, parametrised instruction memory for the 16-bit MIPS datapath. It replaces the fixed, combinational, initial-block program ROM. The fetch side supplies instructions to IF with a registered read. The load side is a streaming program-load port that a testbench or host uses to write a program at run time. A small state machine arbitrates between RUN (fetch) and LOAD (program write) and reports load overflow and out-of-range fetch faults.

Parameters:
DATA_W, 16, instruction width in bits
DEPTH, 64, number of instruction words; any value 2..65536
ADDR_W, 16, width of the word address on the fetch port
NOP_WORD, 16'h0000, value returned on an out-of-range fetch

Ports:
Clk  in  1  single system clock, rising edge
Reset  in  1  synchronous, active-high reset
Fetch_Req  in  1  fetch request; accepted when Fetch_Ready=1
Addr  in  ADDR_W  word address of instruction (PC, word-indexed)
Fetch_Ready  out  1  1 in RUN, 0 in LOAD
Data_Out  out  DATA_W  fetched instruction (registered)
Data_Valid  out  1  one-cycle pulse: Data_Out updated this cycle
Fetch_Fault  out  1  registered with Data_Valid: last fetch address >= DEPTH
Load_Start  in  1  pulse: enter LOAD, write pointer := Load_Base
Load_Base  in  ADDR_W  first word address of the load
Load_Valid  in  1  Load_Data valid this cycle
Load_Data  in  DATA_W  instruction word to write
Load_Last  in  1  qualifies Load_Valid: final word of the program
Load_Busy  out  1  1 while in LOAD
Load_Ovf  out  1  sticky: a load write was attempted at pointer >= DEPTH

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=RUN, write pointer=0, Data_Out=NOP_WORD, Data_Valid=0, Fetch_Fault=0, Load_Ovf=0. Memory array contents are NOT cleared by Reset.
- Reset mid-load: the load aborts. Words already written stay written.
- States and transitions:
  - RUN -> LOAD on Load_Start.
  - LOAD -> RUN on an accepted Load_Valid & Load_Last.
  - LOAD -> RUN on Load_Start=0 & Load_Valid=1 when the pointer reaches DEPTH (see overflow).
- Fetch, RUN only. Fetch_Req=1 at edge n gives, at edge n+1:
  - Data_Out = mem[Addr] if Addr < DEPTH, else NOP_WORD.
  - Data_Valid=1.
  - Fetch_Fault=(Addr >= DEPTH).
  - Latency is exactly 1 cycle, with back-to-back fetches every cycle.
- Without a fetch: Data_Out holds its value, and Data_Valid and Fetch_Fault return to 0.
- Fetch_Req while Fetch_Ready=0 is ignored: no Data_Valid, Data_Out held.
- Load, LOAD only. Each cycle with Load_Valid=1:
  - If pointer < DEPTH: mem[pointer] := Load_Data and pointer increments. Pointer width is ADDR_W+1, so it never wraps.
  - If pointer >= DEPTH: no write, Load_Ovf := 1, state := RUN.
  - Load_Valid outside LOAD is ignored.
- Write-then-read: a word written in cycle n is fetchable from edge n+1 once state is RUN. There is no read/write collision because fetch and load are exclusive.
- Simultaneous events:
  - Load_Start in RUN together with Fetch_Req: Load_Start wins and the fetch is dropped. Fetch_Ready is combinationally 0 when Load_Start=1.
  - Load_Start during LOAD restarts the load at the new Load_Base. A same-cycle Load_Valid is ignored.
  - Load_Valid & Load_Last on the cycle that overflows: Load_Ovf=1 and state := RUN.
- Load_Ovf clears only on Reset or on the next Load_Start.
- Load_Busy = (state == LOAD), registered.

Decomposition:
- Shared package instr_mem_pkg holds:
  - state encoding constants ST_RUN=1'b0 and ST_LOAD=1'b1;
  - the default NOP_WORD;
  - the DATA_W default of 16, shared with the datapath.
- One natural sub-module: imem_ram, a single-port synchronous RAM (DEPTH x DATA_W) with write enable and a registered read. The top level holds the FSM, write pointer, range check and output muxing.

Test Plan:
- Reset, then Load_Start with Load_Base=0 and words 16'h8000, 16'h8111, 16'h2012 (last on the third) -> Load_Busy=1 for 3 cycles, then 0, Load_Ovf=0.
- Fetch Addr=0,1,2 on consecutive cycles -> Data_Out = 8000, 8111, 2012 on the next three edges, Data_Valid=1 each, Fetch_Fault=0.
- Fetch Addr=64 with DEPTH=64 -> one cycle later Data_Out=NOP_WORD, Data_Valid=1, Fetch_Fault=1. The next idle cycle gives Data_Valid=0, Fetch_Fault=0, Data_Out held.
- Load_Base=62, 4 words without Load_Last -> mem[62], mem[63] written, Load_Ovf=1, state RUN after the 3rd word. The 4th word is ignored and Fetch_Ready=1.
- Fetch_Req held during a load of 2 words -> no Data_Valid pulses while Load_Busy=1. Fetching after the load returns the new contents.
- Reset asserted mid-load after 1 of 3 words -> state RUN, Load_Busy=0, Load_Ovf=0, Data_Out=NOP_WORD. The word already written is still readable.
